// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the single-cycle processor.
//
// The block owns the PC register. Each cycle it selects either the
// sequential address PC+4 or the branch/jump target, which is PC+4 plus a
// sign-extended 8-bit word offset. The PC is frozen while either cache
// reports busywait. Stalled cycles are counted in a saturating 16-bit
// counter for performance debug.
//
// Optional feature macro: PCSEQ_BNE_EN adds the BRANCH_NE input, which
// provides branch-if-not-equal.
//
// Ports:
//   CLK             system clock; all state updates on the rising edge
//   RESET           synchronous active-high reset
//   INSTR_BUSYWAIT  instruction cache miss in progress
//   DATA_BUSYWAIT   data cache access in progress
//   JUMP            unconditional jump
//   BRANCH          branch-if-equal
//   BRANCH_NE       branch-if-not-equal (only with PCSEQ_BNE_EN)
//   ZERO            ALU zero flag
//   OFFSET[7:0]     signed word offset
//   PC[31:0]        current instruction address
//   PC_VALID        PC holds a fetchable address
//   REDIRECT        one-cycle pulse after a taken jump/branch is applied
//   STALL_CYCLES    saturating count of stalled cycles
module pc_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        INSTR_BUSYWAIT,
  input  logic        DATA_BUSYWAIT,
  input  logic        JUMP,
  input  logic        BRANCH,
`ifdef PCSEQ_BNE_EN
  input  logic        BRANCH_NE,
`endif
  input  logic        ZERO,
  input  logic [7:0]  OFFSET,
  output logic [31:0] PC,
  output logic        PC_VALID,
  output logic        REDIRECT,
  output logic [15:0] STALL_CYCLES
);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic        redirect_q, redirect_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;

  logic [31:0] seq;
  logic [31:0] target;
  logic        taken;
  logic        stall;

  always_comb begin
    seq    = pc_q + 32'd4;
    target = seq + {{22{OFFSET[7]}}, OFFSET, 2'b00};
`ifdef PCSEQ_BNE_EN
    taken  = JUMP | (BRANCH & ZERO) | (BRANCH_NE & ~ZERO);
`else
    taken  = JUMP | (BRANCH & ZERO);
`endif
    stall  = INSTR_BUSYWAIT | DATA_BUSYWAIT;
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pc_valid_d     = pc_valid_q;
    redirect_d     = redirect_q;
    stall_cycles_d = stall_cycles_q;
    case (state_q)
      S_INIT: begin
        // Busywait is ignored here; the first fetch address is always 0.
        state_d    = S_RUN;
        pc_valid_d = 1'b1;
        redirect_d = 1'b0;
      end
      S_RUN, S_STALL: begin
        if (stall) begin
          state_d    = S_STALL;
          redirect_d = 1'b0;
          if (stall_cycles_q != '1) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
          end
        end else begin
          // Leaving STALL uses only the controls present at this edge.
          state_d    = S_RUN;
          pc_d       = taken ? target : seq;
          redirect_d = taken;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= S_INIT;
      pc_q           <= '0;
      pc_valid_q     <= 1'b0;
      redirect_q     <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pc_valid_q     <= pc_valid_d;
      redirect_q     <= redirect_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign PC           = pc_q;
  assign PC_VALID     = pc_valid_q;
  assign REDIRECT     = redirect_q;
  assign STALL_CYCLES = stall_cycles_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed vector table, hand-written
// multi-cycle sequences (saturation, BNE), and randomized stimulus
// checked against a behavioural model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, ib, db, jmp, br, bne, zr;
  logic [7:0]  off;
  logic [31:0] pc;
  logic        pc_valid, redirect;
  logic [15:0] stall_cycles;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .CLK            (clk),
    .RESET          (rst),
    .INSTR_BUSYWAIT (ib),
    .DATA_BUSYWAIT  (db),
    .JUMP           (jmp),
    .BRANCH         (br),
`ifdef PCSEQ_BNE_EN
    .BRANCH_NE      (bne),
`endif
    .ZERO           (zr),
    .OFFSET         (off),
    .PC             (pc),
    .PC_VALID       (pc_valid),
    .REDIRECT       (redirect),
    .STALL_CYCLES   (stall_cycles)
  );

  typedef struct {
    logic        rst, ib, db, jmp, br, zr;
    logic [7:0]  off;
    logic [31:0] pc;
    logic        v, rd;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic i, logic d, logic j, logic b,
                              logic z, logic [7:0] o, logic [31:0] p,
                              logic v, logic rd, logic [15:0] sc);
    vec_t t;
    t.rst = r; t.ib = i; t.db = d; t.jmp = j; t.br = b; t.zr = z;
    t.off = o; t.pc = p; t.v = v; t.rd = rd; t.sc = sc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic i, input logic d, input logic j,
                       input logic b, input logic n, input logic z, input logic [7:0] o);
    rst = r; ib = i; db = d; jmp = j; br = b; bne = n; zr = z; off = o;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_v, m_rd;
  int          m_cnt;

  task automatic model_step(input logic r, input logic i, input logic d, input logic j,
                            input logic b, input logic n, input logic z, input logic [7:0] o);
    logic tk;
    int   offs;
    if (r) begin
      m_pc = 32'd0; m_v = 1'b0; m_rd = 1'b0; m_cnt = 0;
    end else if (!m_v) begin
      m_v = 1'b1; m_rd = 1'b0;
    end else if (i || d) begin
      m_rd  = 1'b0;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else begin
      tk = j || (b && z);
`ifdef PCSEQ_BNE_EN
      tk = tk || (n && !z);
`endif
      offs = int'($signed(o));
      m_pc = m_pc + 32'd4 + (tk ? 32'(offs * 4) : 32'd0);
      m_rd = tk;
    end
  endtask

  initial begin
    rst = 1'b1; ib = 0; db = 0; jmp = 0; br = 0; bne = 0; zr = 0; off = '0;
    #1;

    //          rst ib db j  b  z  off    pc            v  rd sc
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 32'h0,        1, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 32'h4,        1, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 32'h8,        1, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 32'hC,        1, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h04, 32'h20,       1, 1, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 8'hFE, 32'h1C,       1, 1, 16'd0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h03, 32'h2C,       1, 1, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 8'h7F, 32'h30,       1, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 8'h00, 32'h34,       1, 1, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 32'h38,       1, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 32'h3C,       1, 1, 16'd0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h00, 32'h40,       1, 1, 16'd0));
    // stall at 0x40 with JUMP toggling
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'h10, 32'h40,       1, 0, 16'd1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h10, 32'h40,       1, 0, 16'd2));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'h10, 32'h40,       1, 0, 16'd3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h10, 32'h40,       1, 0, 16'd4));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 8'h10, 32'h40,       1, 0, 16'd5));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'h01, 32'h48,       1, 1, 16'd5));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 8'h00, 32'h48,       1, 0, 16'd6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 32'h4C,       1, 0, 16'd6));
    // wrap
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 32'h0,        1, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 8'hFE, 32'hFFFFFFFC, 1, 1, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 32'h0,        1, 0, 16'd0));
    // busywait ignored in INIT, then reset mid-stall
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 16'd0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 32'h0,        1, 0, 16'd0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 32'h0,        1, 0, 16'd1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 32'h0,        1, 0, 16'd2));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 8'h00, 32'h0,        0, 0, 16'd0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 8'h00, 32'h0,        1, 0, 16'd0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 8'h00, 32'h4,        1, 0, 16'd0));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].ib, tbl[k].db, tbl[k].jmp, tbl[k].br, 1'b0,
            tbl[k].zr, tbl[k].off);
      chk($sformatf("vec%0d_pc", k),       pc,                  tbl[k].pc);
      chk($sformatf("vec%0d_valid", k),    {31'd0, pc_valid},   {31'd0, tbl[k].v});
      chk($sformatf("vec%0d_redirect", k), {31'd0, redirect},   {31'd0, tbl[k].rd});
      chk($sformatf("vec%0d_stall", k),    {16'd0, stall_cycles}, {16'd0, tbl[k].sc});
    end

`ifdef PCSEQ_BNE_EN
    drive(1, 0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 0, 0, 0, 8'h03);
    chk("bne_setup_pc", pc, 32'h10);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h04);
    chk("bne_taken_pc", pc, 32'h24);
    chk("bne_taken_rd", {31'd0, redirect}, 32'd1);
    drive(0, 0, 0, 0, 0, 1, 1, 8'h04);
    chk("bne_not_taken_pc", pc, 32'h28);
    chk("bne_not_taken_rd", {31'd0, redirect}, 32'd0);
`endif

    // Saturation: 70000 stalled edges after INIT
    drive(1, 0, 0, 0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 70000; k++) begin
      drive(0, 0, 1, k[0], 0, 0, 0, 8'h00);
      if (k == 65534) chk("sat_65534", {16'd0, stall_cycles}, 32'h0000FFFE);
      if (k == 65535) chk("sat_65535", {16'd0, stall_cycles}, 32'h0000FFFF);
    end
    chk("sat_70000", {16'd0, stall_cycles}, 32'h0000FFFF);
    chk("sat_pc_hold", pc, 32'h0);

    // Randomized run against the model
    m_pc = 32'hDEAD; m_v = 1'b1; m_rd = 1'b1; m_cnt = 7;
    for (int k = 0; k < 2000; k++) begin
      logic r, i, d, j, b, n, z;
      logic [7:0] o;
      r = (k == 0) || ($urandom_range(0, 49) == 0);
      i = ($urandom_range(0, 9) < 2);
      d = ($urandom_range(0, 9) < 1);
      j = ($urandom_range(0, 9) < 2);
      b = ($urandom_range(0, 9) < 3);
      n = ($urandom_range(0, 9) < 3);
      z = 1'($urandom);
      o = 8'($urandom);
      model_step(r, i, d, j, b, n, z, o);
      drive(r, i, d, j, b, n, z, o);
      chk("rnd_pc",       pc, m_pc);
      chk("rnd_valid",    {31'd0, pc_valid}, {31'd0, m_v});
      chk("rnd_redirect", {31'd0, redirect}, {31'd0, m_rd});
      chk("rnd_stall",    {16'd0, stall_cycles}, 32'(m_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
